// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around dmem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] adr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              err0;
    logic [DATA_W-1:0] rdata0;
    logic              stall0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] adr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic              err1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_w;
    logic              mem_r;
    logic [DATA_W-1:0] mem_dataout;

    modport slave (
        input  req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_dataout,
        output ack0, err0, rdata0, stall0, ack1, err1, rdata1,
        output mem_adr, mem_datain, mem_w, mem_r
    );

    modport master (
        output req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_dataout,
        input  ack0, err0, rdata0, stall0, ack1, err1, rdata1,
        input  mem_adr, mem_datain, mem_w, mem_r
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 64-bit data memory: each access runs
// IDLE (latch + bounds check) -> ACCESS (one memory cycle) -> RESP (ack pulse).
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_BYTES = 32
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [ADDR_W-1:0] LastLegal = ADDR_W'(MEM_BYTES - 8);

    state_e            state_q, state_d;
    logic              prio_q;  // port that wins the next tie
    logic              sel_q;
    logic              we_q;
    logic              oor_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              any_req;
    logic              win;
    logic [ADDR_W-1:0] win_adr;

    assign any_req = bus.req0 | bus.req1;
    assign win     = (bus.req0 & bus.req1) ? prio_q : bus.req1;
    assign win_adr = win ? bus.adr1 : bus.adr0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q   <= 1'b0;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == StIdle && any_req) begin
            sel_q   <= win;
            we_q    <= win ? bus.we1 : bus.we0;
            adr_q   <= win_adr;
            wdata_q <= win ? bus.wdata1 : bus.wdata0;
            // Full-width unsigned compare also rejects addresses that would wrap.
            oor_q   <= win_adr > LastLegal;
        end else if (state_q == StAccess) begin
            prio_q <= ~sel_q;
            if (oor_q || !we_q) begin
                if (sel_q) begin
                    rdata1_q <= oor_q ? '0 : bus.mem_dataout;
                end else begin
                    rdata0_q <= oor_q ? '0 : bus.mem_dataout;
                end
            end
        end
    end

    always_comb begin
        bus.mem_adr    = adr_q;
        bus.mem_datain = wdata_q;
        bus.mem_r      = (state_q == StAccess) & ~we_q & ~oor_q;
        bus.mem_w      = (state_q == StAccess) & we_q & ~oor_q;
        bus.ack0       = (state_q == StResp) & ~sel_q;
        bus.ack1       = (state_q == StResp) & sel_q;
        bus.err0       = (state_q == StResp) & ~sel_q & oor_q;
        bus.err1       = (state_q == StResp) & sel_q & oor_q;
        bus.rdata0     = rdata0_q;
        bus.rdata1     = rdata1_q;
        bus.stall0     = bus.req0 & ~bus.ack0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model and an expectation
// queue that is filled when requests are driven and drained on each ack.
module tb_dmem_arbiter;
    typedef struct packed {
        logic        port;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mem [32] = '{default: 8'h00};
    logic [63:0] mem_dout;
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          mw_cnt = 0;
    int          mr_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        mem_dout = '0;
        if (bus.mem_adr <= 64'd24) begin
            for (int i = 0; i < 8; i++) mem_dout[8*i +: 8] = mem[bus.mem_adr[4:0] + 5'(i)];
        end
    end
    assign bus.mem_dataout = mem_dout;

    always @(posedge clk) begin
        if (bus.mem_w && bus.mem_adr <= 64'd24) begin
            for (int i = 0; i < 8; i++) mem[bus.mem_adr[4:0] + 5'(i)] <= bus.mem_datain[8*i +: 8];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_w) mw_cnt++;
        if (bus.mem_r) mr_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic err, input logic [63:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic check_ack(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_port"}, 64'(bus.ack1), 64'(e.port));
            chk({tag, "_both"}, 64'(bus.ack0 & bus.ack1), 64'd0);
            chk({tag, "_err"}, 64'(e.port ? bus.err1 : bus.err0), 64'(e.err));
            chk({tag, "_rdata"}, e.port ? bus.rdata1 : bus.rdata0, e.rdata);
        end
    endtask

    task automatic wait_ack(input string tag, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            got = bus.ack0 | bus.ack1;
        end
        chk({tag, "_ack"}, 64'(got), 64'd1);
        if (got) check_ack(tag);
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [63:0] adr, input logic [63:0] wd);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.adr1 = adr; bus.wdata1 = wd;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.adr0 = adr; bus.wdata0 = wd;
        end
    endtask

    // Single access from an idle arbiter: ack is expected two negedges after driving.
    task automatic do_req(input string tag, input logic port, input logic we,
                          input logic [63:0] adr, input logic [63:0] wd,
                          input logic eerr, input logic [63:0] erd);
        int lat;
        drive(port, 1'b1, we, adr, wd);
        push_exp(port, eerr, erd);
        wait_ack(tag, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int mw0;
        int mr0;
        logic ea0;
        logic ea1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

        // Reset state
        @(negedge clk);
        chk("rst_ack0", 64'(bus.ack0), 64'd0);
        chk("rst_ack1", 64'(bus.ack1), 64'd0);
        chk("rst_memw", 64'(bus.mem_w), 64'd0);
        chk("rst_memr", 64'(bus.mem_r), 64'd0);
        chk("rst_rdata0", bus.rdata0, 64'd0);
        chk("rst_memadr", bus.mem_adr, 64'd0);
        chk("rst_stall0", 64'(bus.stall0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: store then load on port 0
        mw0 = mw_cnt;
        do_req("t1_st", 1'b0, 1'b1, 64'd0, 64'h1122334455667788, 1'b0, 64'd0);
        chk("t1_memw_cycles", 64'(mw_cnt - mw0), 64'd1);
        mw0 = mw_cnt;
        mr0 = mr_cnt;
        do_req("t1_ld", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'h1122334455667788);
        chk("t1_ld_memw", 64'(mw_cnt - mw0), 64'd0);
        chk("t1_ld_memr", 64'(mr_cnt - mr0), 64'd1);

        // 2: both ports held high from reset -> 0,1,0,1 with acks 3 cycles apart
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'd8, 64'd0);
        push_exp(1'b0, 1'b0, 64'h1122334455667788);
        push_exp(1'b1, 1'b0, 64'd0);
        push_exp(1'b0, 1'b0, 64'h1122334455667788);
        push_exp(1'b1, 1'b0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ea0 = (c == 2 || c == 8);
            ea1 = (c == 5 || c == 11);
            chk($sformatf("t2_ack0_c%0d", c), 64'(bus.ack0), 64'(ea0));
            chk($sformatf("t2_ack1_c%0d", c), 64'(bus.ack1), 64'(ea1));
            chk($sformatf("t2_stall0_c%0d", c), 64'(bus.stall0), 64'(!ea0));
            if (bus.ack0 | bus.ack1) check_ack($sformatf("t2_c%0d", c));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("t2_sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);

        // 3: port 1 bounds
        do_req("t3_st24", 1'b1, 1'b1, 64'd24, 64'hDEADBEEF01234567, 1'b0, 64'd0);
        do_req("t3_ld24", 1'b1, 1'b0, 64'd24, 64'd0, 1'b0, 64'hDEADBEEF01234567);
        mr0 = mr_cnt;
        do_req("t3_ld25", 1'b1, 1'b0, 64'd25, 64'd0, 1'b1, 64'd0);
        chk("t3_ld25_memr", 64'(mr_cnt - mr0), 64'd0);
        do_req("t3_ldwrap", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 64'd0);

        // 4: operands changed after latching are ignored; port 0 served next
        drive(1'b1, 1'b1, 1'b1, 64'd8, 64'hAA);
        push_exp(1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("t4_memw_access", 64'(bus.mem_w), 64'd1);
        bus.adr1   = 64'd0;
        bus.wdata1 = '1;
        drive(1'b0, 1'b1, 1'b0, 64'd8, 64'd0);
        push_exp(1'b0, 1'b0, 64'hAA);
        push_exp(1'b1, 1'b0, 64'h1122334455667788);
        wait_ack("t4_st", lat);
        chk("t4_st_lat", 64'(lat), 64'd1);
        bus.we1 = 1'b0;
        wait_ack("t4_p0", lat);
        chk("t4_p0_lat", 64'(lat), 64'd3);
        bus.req0 = 1'b0;
        wait_ack("t4_p1", lat);
        chk("t4_p1_lat", 64'(lat), 64'd3);
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("t4_mem8", 64'(mem[8]), 64'hAA);
        chk("t4_mem9", 64'(mem[9]), 64'h00);

        // 5: reset in the ACCESS cycle of a store must not commit it
        do_req("t5_pre", 1'b0, 1'b1, 64'd16, 64'h0123456789ABCDEF, 1'b0, 64'hAA);
        drive(1'b0, 1'b1, 1'b1, 64'd16, 64'hFF);
        @(negedge clk);
        chk("t5_memw_access", 64'(bus.mem_w), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_memw_rst", 64'(bus.mem_w), 64'd0);
        chk("t5_ack0_rst", 64'(bus.ack0), 64'd0);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ack0_after", 64'(bus.ack0), 64'd0);
        chk("t5_mem16", 64'(mem[16]), 64'hEF);
        do_req("t5_ld", 1'b0, 1'b0, 64'd16, 64'd0, 1'b0, 64'h0123456789ABCDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
